// File: rtl/mem_copy_engine.sv
// Block copy engine driving sync_mem: port 0 reads, port 1 writes one cycle behind.
// Optional running checksum of written words when MEM_COPY_CHECKSUM_EN is defined.
module mem_copy_engine #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [DEPTH-1:0] srcBase,
    input  logic [DEPTH-1:0] dstBase,
    input  logic [DEPTH:0]   length,
    output logic             busy,
    output logic             done,
    output logic             memWriteEnable0,
    output logic [WIDTH-1:0] memWriteData0,
    output logic [DEPTH-1:0] memAddress0,
    input  logic [WIDTH-1:0] memReadData0,
    output logic             memWriteEnable1,
    output logic [WIDTH-1:0] memWriteData1,
`ifdef MEM_COPY_CHECKSUM_EN
    output logic [DEPTH-1:0] memAddress1,
    output logic [WIDTH-1:0] checksum
`else
    output logic [DEPTH-1:0] memAddress1
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        LAST,
        DONE
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic [DEPTH:0]   remaining;
    logic [DEPTH-1:0] dstPtr;
    logic             accept;
    logic             launch;

    assign accept = (state == IDLE) && start;
    assign launch = accept && (length != '0);

    assign busy            = (state != IDLE);
    assign done            = (state == DONE);
    assign memWriteEnable0 = 1'b0;
    assign memWriteData0   = '0;
    // Read data is only valid the cycle after the address, so it feeds the write port directly
    assign memWriteData1   = memReadData0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = (length == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (remaining == (DEPTH+1)'(1)) begin
                    stateNext = LAST;
                end
            end
            LAST:    stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            memAddress0     <= '0;
            memAddress1     <= '0;
            memWriteEnable1 <= 1'b0;
            dstPtr          <= '0;
            remaining       <= '0;
        end else begin
            memWriteEnable1 <= (state == READ);
            if (launch) begin
                memAddress0 <= srcBase;
                dstPtr      <= dstBase;
                remaining   <= length;
            end
            if (state == READ) begin
                memAddress0 <= memAddress0 + 1'b1;
                memAddress1 <= dstPtr;
                dstPtr      <= dstPtr + 1'b1;
                remaining   <= remaining - 1'b1;
            end
        end
    end

`ifdef MEM_COPY_CHECKSUM_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= '0;
        end else if (memWriteEnable1) begin
            checksum <= checksum + memReadData0;
        end
    end
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine with a local sync_mem model and a
// sequential reference of the copy (read of word i sees writes up to i-2).
module tb_mem_copy_engine;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] srcBase = '0;
    logic [3:0] dstBase = '0;
    logic [4:0] length = '0;
    logic       busy;
    logic       done;
    logic       we0;
    logic [3:0] wd0;
    logic [3:0] addr0;
    logic [3:0] rdata0 = '0;
    logic       we1;
    logic [3:0] wd1;
    logic [3:0] addr1;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [3:0] checksum;
`endif

    logic [3:0] mem [16];
    int checks = 0;
    int failures = 0;

    mem_copy_engine #(.DEPTH(4), .WIDTH(4)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .srcBase(srcBase),
        .dstBase(dstBase),
        .length(length),
        .busy(busy),
        .done(done),
        .memWriteEnable0(we0),
        .memWriteData0(wd0),
        .memAddress0(addr0),
        .memReadData0(rdata0),
        .memWriteEnable1(we1),
        .memWriteData1(wd1),
`ifdef MEM_COPY_CHECKSUM_EN
        .memAddress1(addr1),
        .checksum(checksum)
`else
        .memAddress1(addr1)
`endif
    );

    always #5 clock = ~clock;

    // sync_mem: registered read returns old data on a same-edge write
    always @(posedge clock) begin
        rdata0 <= mem[addr0];
        if (we0) mem[addr0] <= wd0;
        if (we1) mem[addr1] <= wd1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_random();
        for (int a = 0; a < 16; a++) mem[a] = 4'($urandom_range(0, 15));
    endtask

    task automatic check_mem(input string tag, input logic [3:0] m [16]);
        for (int a = 0; a < 16; a++) check(tag, mem[a], m[a]);
    endtask

    task automatic run_copy(input int src, input int dst, input int len,
                            input int pulseAt);
        logic [3:0] m [16];
        logic [3:0] data [16];
        int sum, expDone, doneAt;
        bit wrExp;
        sum = 0;
        for (int a = 0; a < 16; a++) m[a] = mem[a];
        for (int i = 0; i < len; i++) begin
            data[i] = m[(src + i) & 15];
            if (i > 0) m[(dst + i - 1) & 15] = data[i-1];
            sum += data[i];
        end
        if (len > 0) m[(dst + len - 1) & 15] = data[len-1];
        expDone = (len == 0) ? 1 : len + 2;
        doneAt = 0;
        @(negedge clock);
        srcBase = 4'(src);
        dstBase = 4'(dst);
        length = 5'(len);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        srcBase = 4'($urandom);
        dstBase = 4'($urandom);
        length = 5'($urandom_range(0, 16));
        for (int k = 1; k <= 40 && doneAt == 0; k++) begin
            @(negedge clock);
            wrExp = (len != 0) && (k >= 2) && (k <= len + 1);
            check("busy", busy, 32'(k <= expDone));
            check("done", done, 32'(k == expDone));
            check("we1", we1, 32'(wrExp));
            check("we0", we0, 0);
            if (len != 0 && k <= len) check("rdaddr", addr0, 32'((src + k - 1) & 15));
            if (wrExp) check("wraddr", addr1, 32'((dst + k - 2) & 15));
`ifdef MEM_COPY_CHECKSUM_EN
            if (k == expDone) check("checksum", checksum, 32'(sum & 15));
`endif
            if (done) doneAt = k;
            if (k == pulseAt) begin
                start = 1'b1;
                srcBase = 4'($urandom);
                dstBase = 4'($urandom);
                length = 5'($urandom_range(1, 16));
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("doneAt", doneAt, expDone);
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            check("idleBusy", busy, 0);
            check("idleDone", done, 0);
            check("idleWe1", we1, 0);
        end
`ifdef MEM_COPY_CHECKSUM_EN
        check("cksumHold", checksum, 32'(sum & 15));
`endif
        check_mem("mem", m);
    endtask

    initial begin
        logic [3:0] m [16];
        fill_random();
        #2;
        check("rstBusy", busy, 0);
        check("rstDone", done, 0);
        check("rstWe1", we1, 0);
        check("rstAddr0", addr0, 0);
        check("rstAddr1", addr1, 0);
`ifdef MEM_COPY_CHECKSUM_EN
        check("rstCksum", checksum, 0);
`endif
        @(negedge clock);
        reset = 1'b0;

        // Four-word copy
        for (int a = 0; a < 4; a++) mem[a] = 4'(a + 1);
        run_copy(0, 8, 4, 0);
        for (int a = 0; a < 4; a++) check("copy4", mem[8 + a], 32'(a + 1));

        // Zero length leaves memory untouched
        run_copy(5, 9, 0, 0);

        // Wrap-around
        mem[14] = 4'hA; mem[15] = 4'hB; mem[0] = 4'hC; mem[1] = 4'hD;
        run_copy(14, 2, 4, 0);
        check("wrap0", mem[2], 4'hA);
        check("wrap1", mem[3], 4'hB);
        check("wrap2", mem[4], 4'hC);
        check("wrap3", mem[5], 4'hD);

        // Overlap by one: memmove result
        for (int a = 0; a < 4; a++) mem[a] = 4'(a + 1);
        run_copy(0, 1, 4, 0);
        for (int a = 0; a < 4; a++) check("overlap", mem[1 + a], 32'(a + 1));

        // Reset just after the third edge of an 8-word copy
        fill_random();
        for (int a = 0; a < 16; a++) m[a] = mem[a];
        m[10] = mem[3];
        m[11] = mem[4];
        @(negedge clock);
        srcBase = 4'd3;
        dstBase = 4'd10;
        length = 5'd8;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(posedge clock);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("midBusy", busy, 0);
        check("midDone", done, 0);
        check("midWe1", we1, 0);
        check("midAddr0", addr0, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_mem("midMem", m);
        run_copy(0, 8, 5, 0);

        // Start while busy is ignored; checksum of 4,5,6,7 is 6
        for (int a = 0; a < 4; a++) mem[a] = 4'(a + 4);
        run_copy(0, 8, 4, 3);
        for (int a = 0; a < 4; a++) check("ignStart", mem[8 + a], 32'(a + 4));
`ifdef MEM_COPY_CHECKSUM_EN
        check("cksum6", checksum, 6);
`endif

        // Randomized copies, some with a stray start mid-copy
        for (int n = 0; n < 40; n++) begin
            int len;
            fill_random();
            len = $urandom_range(0, 16);
            run_copy($urandom_range(0, 15), $urandom_range(0, 15), len,
                     $urandom_range(0, (len == 0) ? 1 : len + 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
